// File: rtl/sisc_ctrl_fsm_if.sv
// sisc_ctrl_fsm_if: instruction/status inputs, memory handshake and datapath controls of the SISC sequencer
interface sisc_ctrl_fsm_if #(
    parameter int OP_W     = 4,
    parameter int MM_W     = 4,
    parameter int ALU_OP_W = 2
);
    logic [OP_W-1:0]     opcode;
    logic [MM_W-1:0]     mm;
    logic [MM_W-1:0]     stat;
    logic                mem_ack;
    logic                rf_we;
    logic                wb_sel;
    logic [ALU_OP_W-1:0] alu_op;
    logic                ir_load;
    logic                pc_write;
    logic                pc_sel;
    logic                br_sel;
    logic                mem_req;
    logic                dm_we;
    logic                swp_sel;
    logic                halted;
    logic [2:0]          state;
    modport master (
        input  opcode, mm, stat, mem_ack,
        output rf_we, wb_sel, alu_op, ir_load, pc_write, pc_sel, br_sel,
               mem_req, dm_we, swp_sel, halted, state
    );
    modport slave (
        output opcode, mm, stat, mem_ack,
        input  rf_we, wb_sel, alu_op, ir_load, pc_write, pc_sel, br_sel,
               mem_req, dm_we, swp_sel, halted, state
    );
endinterface

// File: rtl/sisc_ctrl_fsm.sv
// sisc_ctrl_fsm: multi-cycle fetch/decode/execute/mem/writeback sequencer with branch, memory handshake, SWP and halt
module sisc_ctrl_fsm #(
    parameter int OP_W     = 4,
    parameter int MM_W     = 4,
    parameter int ALU_OP_W = 2,
    parameter int AM_IMM   = 8
) (
    input logic             clk,
    input logic             rst_f,
    sisc_ctrl_fsm_if.master bus
);
    typedef enum logic [2:0] {
        START0    = 3'd0,
        START1    = 3'd1,
        FETCH     = 3'd2,
        DECODE    = 3'd3,
        EXECUTE   = 3'd4,
        MEM       = 3'd5,
        WRITEBACK = 3'd6,
        HALT      = 3'd7
    } state_t;

    state_t state_q, state_d;
    logic   swp_q, swp_d;

    logic is_lod, is_str, is_swp, is_bra, is_brr, is_bne, is_bnr, is_alu, is_hlt;
    logic is_ls, cond, taken;

    assign is_lod = bus.opcode == OP_W'(1);
    assign is_str = bus.opcode == OP_W'(2);
    assign is_swp = bus.opcode == OP_W'(3);
    assign is_bra = bus.opcode == OP_W'(4);
    assign is_brr = bus.opcode == OP_W'(5);
    assign is_bne = bus.opcode == OP_W'(6);
    assign is_bnr = bus.opcode == OP_W'(7);
    assign is_alu = bus.opcode == OP_W'(8);
    assign is_hlt = bus.opcode == OP_W'(15);
    assign is_ls  = is_lod | is_str;
    assign cond   = |(bus.stat & bus.mm);
    assign taken  = ((is_bra | is_brr) & cond) | ((is_bne | is_bnr) & ~cond);
    assign bus.state = state_q;

    // State and SWP pass flag; reset abandons any instruction in flight
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q <= START0;
            swp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            swp_q   <= swp_d;
        end
    end

    // Next state and Moore control decode; START0 decodes to all-zero outputs
    always_comb begin
        state_d      = START0;
        bus.rf_we    = 1'b0;
        bus.wb_sel   = 1'b0;
        bus.alu_op   = '0;
        bus.ir_load  = 1'b0;
        bus.pc_write = 1'b0;
        bus.pc_sel   = 1'b0;
        bus.br_sel   = 1'b0;
        bus.mem_req  = 1'b0;
        bus.dm_we    = 1'b0;
        bus.swp_sel  = 1'b0;
        bus.halted   = 1'b0;
        case (state_q)
            START0: state_d = START1;
            START1: state_d = FETCH;
            FETCH: begin
                state_d      = DECODE;
                bus.ir_load  = 1'b1;
                bus.pc_write = 1'b1;
            end
            DECODE: state_d = is_hlt ? HALT : EXECUTE;
            EXECUTE: begin
                state_d      = MEM;
                bus.alu_op   = is_alu ? ALU_OP_W'({1'b0, bus.mm == MM_W'(AM_IMM)})
                             : is_ls  ? ALU_OP_W'(2'b10) : '0;
                bus.pc_write = taken;
                bus.pc_sel   = taken;
                bus.br_sel   = taken & (is_brr | is_bnr);
            end
            MEM: begin
                state_d     = (is_ls && !bus.mem_ack) ? MEM : WRITEBACK;
                bus.mem_req = is_ls;
                bus.dm_we   = is_str;
            end
            WRITEBACK: begin
                state_d     = (is_swp && !swp_q) ? WRITEBACK : FETCH;
                bus.rf_we   = is_alu | is_lod | is_swp;
                bus.wb_sel  = is_lod;
                bus.swp_sel = is_swp & swp_q;
            end
            HALT: begin
                state_d    = HALT;
                bus.halted = 1'b1;
            end
            default: state_d = START0;
        endcase
        swp_d = (state_d == FETCH) ? 1'b0 : (state_q == WRITEBACK && is_swp) ? 1'b1 : swp_q;
    end
endmodule
